// File: rtl/ex_mem_pipe_if.sv
// EX->MEM pipeline register bus: EX-side inputs, control in, and the registered MEM-side view.
// The master drives the EX side and control; the slave is the pipeline register.
interface ex_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic              RegWrite_in;
    logic              MemtoReg_in;
    logic              MemRead_in;
    logic              MemWrite_in;
    logic              Branch_in;
    logic              zero_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] write_data_in;
    logic [DATA_W-1:0] branch_target_in;
    logic [REG_AW-1:0] dest_reg_in;

    logic              valid_out;
    logic              RegWrite_out;
    logic              MemtoReg_out;
    logic              MemRead_out;
    logic              MemWrite_out;
    logic              pc_src;
    logic [DATA_W-1:0] alu_result_out;
    logic [DATA_W-1:0] write_data_out;
    logic [DATA_W-1:0] branch_target_out;
    logic [REG_AW-1:0] dest_reg_out;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output stall, flush, valid_in, RegWrite_in, MemtoReg_in, MemRead_in,
               MemWrite_in, Branch_in, zero_in, alu_result_in, write_data_in,
               branch_target_in, dest_reg_in,
        input  valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
               pc_src, alu_result_out, write_data_out, branch_target_out,
               dest_reg_out, bubble_cnt
    );

    modport slave (
        input  stall, flush, valid_in, RegWrite_in, MemtoReg_in, MemRead_in,
               MemWrite_in, Branch_in, zero_in, alu_result_in, write_data_in,
               branch_target_in, dest_reg_in,
        output valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
               pc_src, alu_result_out, write_data_out, branch_target_out,
               dest_reg_out, bubble_cnt
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid bit, stall hold, flush bubbles, branch resolve
// and a saturating bubble counter. Every output is a flop output.
module ex_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_pipe_if.slave bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              memread_q, memread_d;
    logic              memwrite_q, memwrite_d;
    logic              pc_src_q, pc_src_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic              bubble_s;

    // Next-state selection: flush > stall > load (reset applied in the flop block).
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        pc_src_d   = pc_src_q;
        alu_d      = alu_q;
        wdata_d    = wdata_q;
        target_d   = target_q;
        dest_d     = dest_q;
        bubble_s   = 1'b0;
        if (bus.flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            pc_src_d   = 1'b0;
            alu_d      = {DATA_W{1'b0}};
            wdata_d    = {DATA_W{1'b0}};
            target_d   = {DATA_W{1'b0}};
            dest_d     = {REG_AW{1'b0}};
            bubble_s   = 1'b1;
        end else if (bus.stall) begin
            bubble_s   = 1'b0;
        end else begin
            // Side-effecting controls are masked so an invalid entry can never write.
            valid_d    = bus.valid_in;
            regwrite_d = bus.RegWrite_in & bus.valid_in;
            memtoreg_d = bus.MemtoReg_in & bus.valid_in;
            memread_d  = bus.MemRead_in & bus.valid_in;
            memwrite_d = bus.MemWrite_in & bus.valid_in;
            pc_src_d   = bus.Branch_in & bus.zero_in & bus.valid_in;
            alu_d      = bus.alu_result_in;
            wdata_d    = bus.write_data_in;
            target_d   = bus.branch_target_in;
            dest_d     = bus.dest_reg_in;
            bubble_s   = ~bus.valid_in;
        end
        if (bubble_s) begin
            bcnt_d = sat_inc(bcnt_q);
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // Pipeline state flops with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            pc_src_q   <= 1'b0;
            alu_q      <= {DATA_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            target_q   <= {DATA_W{1'b0}};
            dest_q     <= {REG_AW{1'b0}};
            bcnt_q     <= {CNT_W{1'b0}};
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            pc_src_q   <= pc_src_d;
            alu_q      <= alu_d;
            wdata_q    <= wdata_d;
            target_q   <= target_d;
            dest_q     <= dest_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign bus.valid_out         = valid_q;
    assign bus.RegWrite_out      = regwrite_q;
    assign bus.MemtoReg_out      = memtoreg_q;
    assign bus.MemRead_out       = memread_q;
    assign bus.MemWrite_out      = memwrite_q;
    assign bus.pc_src            = pc_src_q;
    assign bus.alu_result_out    = alu_q;
    assign bus.write_data_out    = wdata_q;
    assign bus.branch_target_out = target_q;
    assign bus.dest_reg_out      = dest_q;
    assign bus.bubble_cnt        = bcnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed scenarios then random traffic, checked against a
// behavioural model; a second instance with a 4-bit counter exercises saturation.
module tb_ex_mem_pipe;

    logic clk;
    logic rst;

    ex_mem_pipe_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) if_a ();
    ex_mem_pipe_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  if_b ();

    ex_mem_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    ex_mem_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    assign if_b.stall            = if_a.stall;
    assign if_b.flush            = if_a.flush;
    assign if_b.valid_in         = if_a.valid_in;
    assign if_b.RegWrite_in      = if_a.RegWrite_in;
    assign if_b.MemtoReg_in      = if_a.MemtoReg_in;
    assign if_b.MemRead_in       = if_a.MemRead_in;
    assign if_b.MemWrite_in      = if_a.MemWrite_in;
    assign if_b.Branch_in        = if_a.Branch_in;
    assign if_b.zero_in          = if_a.zero_in;
    assign if_b.alu_result_in    = if_a.alu_result_in;
    assign if_b.write_data_in    = if_a.write_data_in;
    assign if_b.branch_target_in = if_a.branch_target_in;
    assign if_b.dest_reg_in      = if_a.dest_reg_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Expected architectural view of the MEM-stage entry.
    bit          m_valid, m_rw, m_mtr, m_mr, m_mw, m_pc;
    logic [31:0] m_alu, m_wd, m_bt;
    logic [4:0]  m_dest;
    int          m_cnt, m_cnt4;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_bubble();
        m_valid = 0; m_rw = 0; m_mtr = 0; m_mr = 0; m_mw = 0; m_pc = 0;
        m_alu = 32'd0; m_wd = 32'd0; m_bt = 32'd0; m_dest = 5'd0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_bubble();
            m_cnt = 0;
            m_cnt4 = 0;
        end else if (if_a.flush) begin
            model_bubble();
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
        end else if (!if_a.stall) begin
            m_valid = if_a.valid_in;
            m_rw    = if_a.valid_in && if_a.RegWrite_in;
            m_mtr   = if_a.valid_in && if_a.MemtoReg_in;
            m_mr    = if_a.valid_in && if_a.MemRead_in;
            m_mw    = if_a.valid_in && if_a.MemWrite_in;
            m_pc    = if_a.valid_in && if_a.Branch_in && if_a.zero_in;
            m_alu   = if_a.alu_result_in;
            m_wd    = if_a.write_data_in;
            m_bt    = if_a.branch_target_in;
            m_dest  = if_a.dest_reg_in;
            if (!if_a.valid_in) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("valid", 64'(if_a.valid_out), 64'(m_valid));
        check_eq("regwrite", 64'(if_a.RegWrite_out), 64'(m_rw));
        check_eq("memtoreg", 64'(if_a.MemtoReg_out), 64'(m_mtr));
        check_eq("memread", 64'(if_a.MemRead_out), 64'(m_mr));
        check_eq("memwrite", 64'(if_a.MemWrite_out), 64'(m_mw));
        check_eq("pc_src", 64'(if_a.pc_src), 64'(m_pc));
        check_eq("alu", 64'(if_a.alu_result_out), 64'(m_alu));
        check_eq("wdata", 64'(if_a.write_data_out), 64'(m_wd));
        check_eq("target", 64'(if_a.branch_target_out), 64'(m_bt));
        check_eq("dest", 64'(if_a.dest_reg_out), 64'(m_dest));
        check_eq("cnt", 64'(if_a.bubble_cnt), 64'(m_cnt));
        check_eq("cnt4", 64'(if_b.bubble_cnt), 64'(m_cnt4));
        check_eq("valid4", 64'(if_b.valid_out), 64'(m_valid));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_ctl(input bit v, input bit rw, input bit mtr, input bit mr,
                           input bit mw, input bit br, input bit z);
        if_a.valid_in    = v;
        if_a.RegWrite_in = rw;
        if_a.MemtoReg_in = mtr;
        if_a.MemRead_in  = mr;
        if_a.MemWrite_in = mw;
        if_a.Branch_in   = br;
        if_a.zero_in     = z;
    endtask

    task automatic set_data(input logic [31:0] alu, input logic [31:0] wd,
                            input logic [31:0] bt, input logic [4:0] dest);
        if_a.alu_result_in    = alu;
        if_a.write_data_in    = wd;
        if_a.branch_target_in = bt;
        if_a.dest_reg_in      = dest;
    endtask

    task automatic rand_in();
        set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
        set_data($urandom, $urandom, $urandom, 5'($urandom));
        if_a.stall = ($urandom_range(0, 3) == 0);
        if_a.flush = ($urandom_range(0, 9) == 0);
        rst        = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        model_bubble();
        m_cnt = 0;
        m_cnt4 = 0;

        // Reset with every input high.
        rst = 1'b1;
        if_a.stall = 1'b1;
        if_a.flush = 1'b1;
        set_ctl(1, 1, 1, 1, 1, 1, 1);
        set_data(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F);
        step();
        check_eq("rst_cnt", 64'(if_a.bubble_cnt), 64'd0);
        rst = 1'b0;
        if_a.stall = 1'b0;
        if_a.flush = 1'b0;

        // Basic load.
        set_ctl(1, 1, 0, 0, 0, 0, 0);
        set_data(32'h0000_1234, 32'hA5A5_0001, 32'h0000_0040, 5'd9);
        step();
        check_eq("load_alu", 64'(if_a.alu_result_out), 64'h1234);
        check_eq("load_dest", 64'(if_a.dest_reg_out), 64'd9);

        // Stall holds A for three edges while B waits on the inputs.
        set_ctl(1, 0, 1, 1, 0, 0, 0);
        set_data(32'hBBBB_0002, 32'h0000_0002, 32'h0000_0080, 5'd17);
        if_a.stall = 1'b1;
        repeat (3) step();
        check_eq("stall_hold", 64'(if_a.alu_result_out), 64'h1234);
        if_a.stall = 1'b0;
        step();
        check_eq("stall_rel", 64'(if_a.alu_result_out), 64'hBBBB_0002);

        // Store entry, then flush during stall.
        set_ctl(1, 0, 0, 0, 1, 0, 0);
        set_data(32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 5'd0);
        step();
        check_eq("mw_set", 64'(if_a.MemWrite_out), 64'd1);
        if_a.stall = 1'b1;
        if_a.flush = 1'b1;
        step();
        check_eq("flush_mw", 64'(if_a.MemWrite_out), 64'd0);
        check_eq("flush_cnt", 64'(if_a.bubble_cnt), 64'd1);
        if_a.stall = 1'b0;
        if_a.flush = 1'b0;

        // Branch taken, then same branch from an invalid slot.
        set_ctl(1, 0, 0, 0, 0, 1, 1);
        set_data(32'd0, 32'd0, 32'h0040_0010, 5'd0);
        step();
        check_eq("br_taken", 64'(if_a.pc_src), 64'd1);
        set_ctl(0, 1, 1, 1, 1, 1, 1);
        step();
        check_eq("br_inval", 64'(if_a.pc_src), 64'd0);
        check_eq("br_cnt", 64'(if_a.bubble_cnt), 64'd2);

        // Twenty consecutive bubbles saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            if_a.flush = (i % 2 == 0);
            set_ctl(0, 1, 0, 0, 1, 0, 0);
            step();
        end
        if_a.flush = 1'b0;
        check_eq("sat4", 64'(if_b.bubble_cnt), 64'd15);
        check_eq("cnt22", 64'(if_a.bubble_cnt), 64'd22);
        step();
        check_eq("sat4_hold", 64'(if_b.bubble_cnt), 64'd15);

        // Reset in the middle of a stall.
        if_a.stall = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_a.stall = 1'b0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rand_in();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX→MEM pipeline register for the 32-bit MIPS core, sitting between the ALU stage and the data-memory stage. Captures the execute-stage control bits and datapath payload, adds a valid bit, stall (hold) and flush (bubble insertion), gates side-effecting controls on invalid entries, resolves the branch decision for the MEM stage, and keeps a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, datapath width (ALU result, store data, branch target)
- REG_AW, 5, register-file address width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current contents (MEM stage not ready)
- flush  in  1  replace contents with bubble on next edge
- valid_in  in  1  EX stage holds a real instruction
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  EX control bits
- zero_in  in  1  ALU zero flag
- alu_result_in  in  DATA_W  ALU result / memory address
- write_data_in  in  DATA_W  store data (rt value after forwarding)
- branch_target_in  in  DATA_W  computed branch target
- dest_reg_in  in  REG_AW  destination register (already RegDst-selected)
- valid_out  out  1  entry is a real instruction
- RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out  out  1 each  registered controls, forced 0 when valid_out=0
- pc_src  out  1  registered Branch & zero & valid
- alu_result_out, write_data_out, branch_target_out  out  DATA_W  registered payload
- dest_reg_out  out  REG_AW  registered destination
- bubble_cnt  out  CNT_W  count of edges on which a bubble was loaded

## Operation
- Per-edge priority: rst > flush > stall > load.
- rst: valid_out, all control outputs, pc_src, payload, dest_reg_out, bubble_cnt ← 0.
- flush (any stall value): valid_out ← 0, all controls and pc_src ← 0; payload and dest_reg_out ← 0; bubble_cnt increments.
- stall, no flush: every output holds; bubble_cnt holds.
- load (no stall, no flush): valid_out ← valid_in; controls ← *_in & valid_in; pc_src ← Branch_in & zero_in & valid_in; payload and dest_reg_out ← inputs unconditionally; bubble_cnt increments if valid_in=0.
- Invariant: valid_out=0 ⇒ RegWrite_out=MemRead_out=MemWrite_out=MemtoReg_out=pc_src=0.
- dest_reg_out=0 with RegWrite_out=1 is legal; downstream ignores writes to $0.
- bubble_cnt saturates at 2^CNT_W−1; no wrap.
- No combinational path input→output; all outputs are flop outputs.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Stall holds indefinitely; releasing stall at edge N loads the inputs present at edge N.
- Flush asserted for one cycle inserts exactly one bubble; held for k cycles inserts k bubbles (counter +k).
- Reset mid-stall or mid-flush: reset wins, all outputs 0 after that edge; first load on the edge after rst deasserts.
- pc_src is valid one cycle after the branch leaves EX; the upstream flush of IF/ID/EX driven from it is the fetch logic's responsibility.

## Test plan
- Reset: drive all inputs 1, rst=1 one edge → every output 0, bubble_cnt=0.
- Load: valid_in=1, RegWrite_in=1, alu_result_in=32'h0000_1234, dest_reg_in=5'd9 → after one edge valid_out=1, RegWrite_out=1, alu_result_out=32'h1234, dest_reg_out=9.
- Stall: load value A, then stall=1 for 3 edges with input B → outputs stay A; stall=0 → B appears next edge.
- Flush beats stall: entry valid with MemWrite_out=1, stall=1 and flush=1 together → valid_out=0, MemWrite_out=0, bubble_cnt +1.
- Branch: Branch_in=1, zero_in=1, valid_in=1 → pc_src=1; same with valid_in=0 → pc_src=0, bubble_cnt +1.
- Saturation: CNT_W=4, 20 consecutive bubbles → bubble_cnt=15 and stays 15.
